// File: rtl/vector_pkg.sv
// Shared types and constants for the vector load unit and its byte assembler.
package vector_pkg;

    localparam int VLEN_BYTES = 16;
    localparam int VREG_W     = 8 * VLEN_BYTES;
    localparam int REG_AW     = 4;
    localparam int LANE_W     = $clog2(VLEN_BYTES);

    typedef logic [VREG_W-1:0] vreg_t;
    typedef logic [REG_AW-1:0] vreg_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE
    } vlu_state_t;

endpackage

// File: rtl/vlu_byte_assembler.sv
// 128-bit staging buffer: clears on a new load and inserts one byte per lane.
module vlu_byte_assembler
    import vector_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [LANE_W-1:0] lane,
    input  logic [7:0]        byte_in,
    output logic [VREG_W-1:0] data
);

    logic [LANE_W+2:0] bit_base;

    // Lane 0 lands in the least significant byte.
    assign bit_base = {lane, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (clear) begin
            data <= '0;
        end else if (wr_en) begin
            data[bit_base +: 8] <= byte_in;
        end
    end

endmodule

// File: rtl/vector_load_unit.sv
// Fills one vector register from byte-wide memory, one outstanding read at a time.
// Optional read timeout enabled by defining VLU_TIMEOUT_EN.
module vector_load_unit
    import vector_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [REG_AW-1:0] dest_reg,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    output logic              wre,
    output logic [REG_AW-1:0] a3,
    output logic [VREG_W-1:0] wd3
);

    vlu_state_t        state;
    vlu_state_t        state_next;
    logic [LANE_W-1:0] idx;
    logic [ADDR_W-1:0] base_q;
    vreg_addr_t        dest_q;
    vreg_addr_t        a3_q;
    vreg_t             wd3_q;
    vreg_t             buffer;
    logic              start_accept;
    logic              byte_wr;
    logic              last_byte;
    logic              timeout_expired;
    logic              timeout_hit;

    assign last_byte = (idx == LANE_W'(VLEN_BYTES - 1));

`ifdef VLU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counts idle WAIT cycles; restarted every time a request is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == REQ) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !mem_rvalid) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout  = ^TIMEOUT;
    assign timeout_expired = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        start_accept = 1'b0;
        byte_wr      = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = REQ;
                end
            end
            REQ: state_next = WAIT;
            WAIT: begin
                // A response in the expiry cycle still wins over the timeout.
                if (mem_rvalid) begin
                    byte_wr    = 1'b1;
                    state_next = last_byte ? WRITE : REQ;
                end else if (timeout_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            base_q <= '0;
            dest_q <= '0;
            a3_q   <= '0;
            wd3_q  <= '0;
        end else begin
            state <= state_next;
            if (start_accept) begin
                base_q <= base_addr;
                dest_q <= dest_reg;
                idx    <= '0;
            end
            if (byte_wr && !last_byte) begin
                idx <= idx + 1'b1;
            end
            if (state == WRITE) begin
                a3_q  <= dest_q;
                wd3_q <= buffer;
            end
        end
    end

    vlu_byte_assembler u_assembler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_accept),
        .wr_en   (byte_wr),
        .lane    (idx),
        .byte_in (mem_rdata),
        .data    (buffer)
    );

    // During WRITE the live buffer is forwarded so the final byte is included.
    assign busy     = (state != IDLE);
    assign done     = (state == WRITE);
    assign wre      = (state == WRITE);
    assign mem_req  = (state == REQ);
    assign mem_addr = base_q + ADDR_W'(idx);
    assign a3       = (state == WRITE) ? dest_q : a3_q;
    assign wd3      = (state == WRITE) ? buffer : wd3_q;
    assign error    = timeout_hit;

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed self-checking bench for vector_load_unit with a latency-configurable byte memory.
module tb_vector_load_unit;

`ifdef VLU_TIMEOUT_EN
    localparam int TB_TIMEOUT = 10;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [31:0]  base_addr;
    logic [3:0]   dest_reg;
    logic         busy;
    logic         done;
    logic         error;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_rvalid;
    logic [7:0]   mem_rdata;
    logic         wre;
    logic [3:0]   a3;
    logic [127:0] wd3;

    int           total;
    int           bad;
    int           cyc;

    int           mem_lat;
    logic [7:0]   key;
    logic         mem_enable;
    int           inject_req;
    int           inject_done;
    logic [7:0]   inject_data;
    logic         pending;
    int           pend_cnt;
    logic [31:0]  pend_addr;
    int           overlap;
    int           rx_count;
    logic [31:0]  addr_q[$];
    int           wr_count;
    int           wr_cyc;
    logic [3:0]   wr_a3;
    logic [127:0] wr_wd3;
    logic         wr_done;
    int           tstart;

    localparam logic [127:0] EXP_100  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] EXP_040  = 128'h4F4E4D4C4B4A49484746454443424140;
    localparam logic [127:0] EXP_WRAP = 128'h0706050403020100FFFEFDFCFBFAF9F8;
    localparam logic [127:0] EXP_K11  = 128'h1E1F1C1D1A1B18191617141512131011;
    localparam logic [127:0] EXP_K5A  = 128'h55545756515053525D5C5F5E59585B5A;

    vector_load_unit #(
        .ADDR_W  (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .dest_reg   (dest_reg),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wre        (wre),
        .a3         (a3),
        .wd3        (wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Memory model and write monitor; responds mem_lat cycles after each request.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    pending    = 1'b0;
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_addr[7:0] ^ key;
                    rx_count   = rx_count + 1;
                end
            end
            if (inject_req != inject_done) begin
                inject_done = inject_req;
                mem_rvalid  = 1'b1;
                mem_rdata   = inject_data;
            end
            if (mem_req) begin
                if (pending) overlap = overlap + 1;
                addr_q.push_back(mem_addr);
                pend_addr = mem_addr;
                pending   = mem_enable;
                pend_cnt  = mem_lat;
            end
            if (wre) begin
                wr_count = wr_count + 1;
                wr_cyc   = cyc;
                wr_a3    = a3;
                wr_wd3   = wd3;
                wr_done  = done;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [3:0] dest);
        start     = 1'b1;
        base_addr = base;
        dest_reg  = dest;
        tstart    = cyc;
        stepCycle();
        start     = 1'b0;
    endtask

    task automatic waitWrite(input int target, input int budget);
        for (int i = 0; i < budget && wr_count < target; i++) stepCycle();
        checkOutput("write_seen", wr_count, target);
    endtask

    initial begin
        int mark;
        int wc;
        int ovl0;
        int rx0;
        int wcyc;
        int t2;

        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; dest_reg = '0;
        mem_lat = 1; key = 8'h00; mem_enable = 1'b1;
        inject_req = 0; inject_done = 0; inject_data = 8'h00;
        pending = 1'b0; pend_cnt = 0; pend_addr = '0;
        overlap = 0; rx_count = 0; wr_count = 0; wr_cyc = 0;
        wr_a3 = '0; wr_wd3 = '0; wr_done = 1'b0; tstart = 0;
        mem_rvalid = 1'b0; mem_rdata = 8'h00;

        repeat (2) stepCycle();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_wre", wre, 0);
        checkOutput("rst_a3", a3, 0);
        checkOutput("rst_wd3", wd3, 0);
        rst_n = 1'b1;
        stepCycle();

        $display("[TB] zero-wait load, base 0x100 dest 5");
        mark = addr_q.size(); wc = wr_count; ovl0 = overlap;
        applyStimulus(32'h100, 4'd5);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_first_req", mem_req, 1);
        waitWrite(wc + 1, 100);
        checkOutput("t1_latency", wr_cyc - tstart, 33);
        checkOutput("t1_a3", wr_a3, 5);
        checkOutput("t1_wd3", wr_wd3, EXP_100);
        checkOutput("t1_done", wr_done, 1);
        checkOutput("t1_nreq", addr_q.size() - mark, 16);
        for (int i = 0; i < 16; i++) checkOutput("t1_addr", addr_q[mark + i], 32'h100 + i);
        stepCycle();
        checkOutput("t1_busy_after", busy, 0);
        checkOutput("t1_done_after", done, 0);
        checkOutput("t1_wre_after", wre, 0);
        checkOutput("t1_a3_hold", a3, 5);
        checkOutput("t1_wd3_hold", wd3, EXP_100);

        $display("[TB] 3-cycle memory, base 0x40 dest 9");
        mem_lat = 3; wc = wr_count;
        applyStimulus(32'h40, 4'd9);
        waitWrite(wc + 1, 200);
        checkOutput("t2_latency", wr_cyc - tstart, 65);
        checkOutput("t2_a3", wr_a3, 9);
        checkOutput("t2_wd3", wr_wd3, EXP_040);
        checkOutput("t2_one_outstanding", overlap, ovl0);
        stepCycle();

        $display("[TB] address wrap, base 0xFFFFFFF8 dest 14");
        mem_lat = 1; mark = addr_q.size(); wc = wr_count;
        applyStimulus(32'hFFFF_FFF8, 4'd14);
        waitWrite(wc + 1, 100);
        checkOutput("t3_wd3", wr_wd3, EXP_WRAP);
        checkOutput("t3_a3", wr_a3, 14);
        checkOutput("t3_addr_first", addr_q[mark], 32'hFFFF_FFF8);
        checkOutput("t3_addr_top", addr_q[mark + 7], 32'hFFFF_FFFF);
        checkOutput("t3_addr_wrapped", addr_q[mark + 8], 32'h0000_0000);
        checkOutput("t3_addr_last", addr_q[mark + 15], 32'h0000_0007);
        stepCycle();

        $display("[TB] start while busy and during WRITE");
        key = 8'h11; mark = addr_q.size(); wc = wr_count;
        applyStimulus(32'h300, 4'd7);
        repeat (8) stepCycle();
        start = 1'b1; base_addr = 32'h900; dest_reg = 4'd12;
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 100 && !wre; i++) stepCycle();
        checkOutput("t4_wre_seen", wre, 1);
        start = 1'b1; base_addr = 32'h700; dest_reg = 4'd4;
        wcyc = cyc;
        checkOutput("t4_one_write", wr_count, wc + 1);
        checkOutput("t4_a3", wr_a3, 7);
        checkOutput("t4_wd3", wr_wd3, EXP_K11);
        checkOutput("t4_nreq", addr_q.size() - mark, 16);
        stepCycle();
        t2 = cyc;
        stepCycle();
        start = 1'b0;
        checkOutput("t4_restart_busy", busy, 1);
        waitWrite(wc + 2, 100);
        checkOutput("t4_second_latency", wr_cyc - t2, 33);
        checkOutput("t4_second_a3", wr_a3, 4);
        checkOutput("t4_second_wd3", wr_wd3, EXP_K11);
        repeat (3) stepCycle();
        inject_data = 8'hEE;
        inject_req  = inject_req + 1;
        repeat (2) stepCycle();
        checkOutput("t4_idle_rvalid_busy", busy, 0);
        checkOutput("t4_idle_rvalid_wd3", wd3, EXP_K11);
        checkOutput("t4_idle_rvalid_wre", wr_count, wc + 2);

        $display("[TB] reset after seven bytes");
        key = 8'h00; wc = wr_count; rx0 = rx_count;
        applyStimulus(32'h500, 4'd3);
        for (int i = 0; i < 100 && (rx_count - rx0) < 7; i++) stepCycle();
        checkOutput("t5_bytes_seen", rx_count - rx0, 7);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_mem_req", mem_req, 0);
        checkOutput("t5_mem_addr", mem_addr, 0);
        checkOutput("t5_wre", wre, 0);
        checkOutput("t5_a3", a3, 0);
        checkOutput("t5_wd3", wd3, 0);
        repeat (2) stepCycle();
        checkOutput("t5_no_write", wr_count, wc);
        rst_n = 1'b1;
        stepCycle();
        key = 8'h5A;
        applyStimulus(32'h600, 4'd2);
        waitWrite(wc + 1, 100);
        checkOutput("t5_after_a3", wr_a3, 2);
        checkOutput("t5_after_wd3", wr_wd3, EXP_K5A);
        checkOutput("t5_after_latency", wr_cyc - tstart, 33);
        stepCycle();

`ifdef VLU_TIMEOUT_EN
        $display("[TB] timeout with silent memory");
        mem_enable = 1'b0; wc = wr_count;
        applyStimulus(32'h800, 4'd6);
        for (int i = 0; i < 50 && !error; i++) stepCycle();
        checkOutput("t6_error_seen", error, 1);
        checkOutput("t6_error_cycle", cyc - (tstart + 1), 10);
        stepCycle();
        checkOutput("t6_error_pulse", error, 0);
        checkOutput("t6_idle", busy, 0);
        checkOutput("t6_no_write", wr_count, wc);
        mem_enable = 1'b1; key = 8'h00;
        applyStimulus(32'h100, 4'd1);
        waitWrite(wc + 1, 100);
        checkOutput("t6_recover_a3", wr_a3, 1);
        checkOutput("t6_recover_wd3", wr_wd3, EXP_100);
`else
        checkOutput("error_tied_low", error, 0);
`endif

        repeat (2) stepCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_load_unit.md
Name: vector_load_unit

Overview:
- Sequential loader that fills one 128-bit vector register from byte-wide data memory.
- Issues 16 single-byte reads, one outstanding at a time, and assembles the bytes into one 128-bit word.
- Delivers the word through a single-cycle write to the vector register file write port (write enable, destination address, 128-bit data).
- Sits directly upstream of the vector register file in the writeback path; started by the decode/control stage for vector load instructions.

Parameters:
- ADDR_W, 32, byte address width of data memory
- VLEN_BYTES, 16, bytes per vector register; VREG_W = 8*VLEN_BYTES = 128
- REG_AW, 4, vector register index width (16 registers)
- TIMEOUT, 255, max cycles to wait for a read response; used only with VLU_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load; honoured only when idle
- base_addr  in  ADDR_W  byte address of lane 0, sampled with start
- dest_reg  in  REG_AW  destination vector register, sampled with start
- busy  out  1  high from the cycle after an accepted start through the WRITE cycle
- done  out  1  one-cycle pulse in the WRITE cycle
- error  out  1  one-cycle timeout pulse; constant 0 without VLU_TIMEOUT_EN
- mem_req  out  1  one-cycle read request
- mem_addr  out  ADDR_W  read address, valid with mem_req
- mem_rvalid  in  1  read data valid
- mem_rdata  in  8  read data byte
- wre  out  1  register file write enable
- a3  out  REG_AW  register file destination address
- wd3  out  VREG_W  register file write data

Behaviour:
- Reset (async, rst_n low): state IDLE; idx=0; buffer=0; busy, done, error, mem_req, wre = 0; mem_addr=0; a3=0; wd3=0.
- FSM states: IDLE, REQ, WAIT, WRITE.
- IDLE: on start, latch base_addr and dest_reg, clear buffer and idx, then go to REQ. start is ignored in every other state; no queueing.
- REQ:
  - mem_req=1 for exactly one cycle.
  - mem_addr = base + idx, computed modulo 2^ADDR_W (wraps past the top of the address space).
  - Next state is WAIT.
- WAIT:
  - On mem_rvalid, write mem_rdata into buffer[8*idx+7 : 8*idx] (lane 0 = least significant byte).
  - If idx == VLEN_BYTES-1, go to WRITE; otherwise increment idx and go to REQ.
  - mem_rvalid is ignored in every state except WAIT.
- WRITE:
  - wre=1, a3 = latched dest, wd3 = buffer (including the byte that arrived in the preceding cycle), done=1, all for one cycle.
  - Next state is IDLE.
  - wre, done and mem_req are 0 in all other cycles.
  - wd3 and a3 hold their last values in other cycles.
- Latency with a zero-wait memory (rvalid the cycle after req): start sampled at cycle T, first mem_req at T+1, WRITE at T+33.
- A start that coincides with WRITE is ignored; a start in the following IDLE cycle is accepted.
- Reset mid-operation aborts immediately: no write is issued and the partial buffer is discarded.

Optional Feature:
- Macro: VLU_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without mem_rvalid.
  - When it reaches TIMEOUT, the unit pulses error for one cycle, returns to IDLE and issues no write.
  - mem_rvalid arriving in the same cycle as the timeout takes priority: the byte is accepted and no error is raised.
- Undefined: no counter; WAIT waits indefinitely; error tied to 0.

Decomposition:
- Package vector_pkg:
  - constants VLEN_BYTES, VREG_W, REG_AW
  - typedef vreg_t (logic [VREG_W-1:0])
  - typedef vreg_addr_t (logic [REG_AW-1:0])
  - enum vlu_state_t {IDLE, REQ, WAIT, WRITE}
- Sub-module vlu_byte_assembler: the 128-bit buffer with clear, lane-indexed byte insert and async reset. The FSM, address generation and timeout counter stay in the top level.

Test Plan:
- Zero-wait memory returning byte = addr[7:0]; start, base=0x100, dest=5: 16 requests at 0x100..0x10F, WRITE at T+33 with a3=5, wd3=0x0F0E...0100, done pulse, busy low the next cycle.
- Memory with 3-cycle response: a single request outstanding at all times; WRITE occurs at T+1+16*4; wd3 correct.
- base=0xFFFFFFF8: addresses wrap 0xFFFFFFF8..0x00000007; wd3 lane order preserved.
- start pulsed during busy and during WRITE: ignored, exactly one write per accepted start; spurious mem_rvalid while in IDLE leaves the buffer unchanged.
- rst_n asserted after 7 bytes: all outputs 0 immediately, no wre; a following load to dest=2 produces correct data with no stale bytes.
- With VLU_TIMEOUT_EN and TIMEOUT=10, memory never responds: error pulses exactly 10 WAIT cycles after the req, wre stays 0, unit returns to IDLE and accepts a new start.
